// File: rtl/pcihellocore_pio_pkg.sv
// Shared register map and edge-select encodings for PCI hello core PIO blocks.
package pcihellocore_pio_pkg;

  localparam int unsigned PIO_ADDR_W = 2;

  localparam logic [PIO_ADDR_W-1:0] ADDR_DATA         = 2'd0;
  localparam logic [PIO_ADDR_W-1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [PIO_ADDR_W-1:0] ADDR_EDGE_CAPTURE = 2'd2;
  localparam logic [PIO_ADDR_W-1:0] ADDR_EDGE_SEL     = 2'd3;

  localparam logic EDGE_FALLING = 1'b0;
  localparam logic EDGE_RISING  = 1'b1;

endpackage

// File: rtl/pcihellocore_debounce_bit.sv
// One input bit: two-flop synchroniser, hold-time debounce counter, and the
// accepted (stable) level with a single-cycle update strobe.
module pcihellocore_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16,
  parameter logic        INIT_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic sync_level,
  output logic update_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             ff1_q;
  logic             ff1_d;
  logic             ff2_q;
  logic             ff2_d;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter only advances while the synchronised level disagrees with the accepted one.
  always_comb begin
    ff1_d    = din;
    ff2_d    = ff1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    update_c = 1'b0;
    if (ff2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ff2_q;
        update_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ff1_q    <= INIT_LEVEL;
      ff2_q    <= INIT_LEVEL;
      stable_q <= INIT_LEVEL;
      cnt_q    <= '0;
    end else begin
      ff1_q    <= ff1_d;
      ff2_q    <= ff2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level      = stable_q;
  assign sync_level = ff2_q;

endmodule

// File: rtl/pcihellocore_key_in.sv
// Avalon-MM input PIO: debounced key levels, edge capture with write-1-to-clear,
// interrupt mask, and a zero-wait-state read mux.
module pcihellocore_key_in #(
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter int unsigned       CNT_W           = 16,
  parameter logic [WIDTH-1:0]  INIT_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  import pcihellocore_pio_pkg::*;

  logic [WIDTH-1:0] data_w;
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] update_c;
  logic [WIDTH-1:0] set_c;
  logic [WIDTH-1:0] clr_c;
  logic             wr_en_c;
  logic             wdata_unused_c;

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] sel_q;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic             irq_q;
  logic             irq_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .INIT_LEVEL      (INIT_LEVEL[i])
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .din        (in_port[i]),
      .level      (data_w[i]),
      .sync_level (sync_w[i]),
      .update_c   (update_c[i])
    );
  end

  // Bits above WIDTH are don't-care on writes.
  assign wdata_unused_c = ^writedata;

  // Register updates; a capture set in the same cycle as its clear takes priority.
  always_comb begin
    wr_en_c = chipselect && !write_n;
    mask_d  = mask_q;
    sel_d   = sel_q;
    clr_c   = '0;
    set_c   = '0;
    if (wr_en_c) begin
      case (address)
        ADDR_IRQ_MASK:     mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE_CAPTURE: clr_c  = writedata[WIDTH-1:0];
        ADDR_EDGE_SEL:     sel_d  = writedata[WIDTH-1:0];
        default:           ;
      endcase
    end
    for (int i = 0; i < WIDTH; i++) begin
      set_c[i] = update_c[i] &&
                 (sync_w[i] ? (sel_q[i] == EDGE_RISING) : (sel_q[i] == EDGE_FALLING));
    end
    cap_d = (cap_q & ~clr_c) | set_c;
    irq_d = |(cap_d & mask_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      sel_q  <= '0;
      cap_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      sel_q  <= sel_d;
      cap_q  <= cap_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:         readdata = 32'(data_w);
      ADDR_IRQ_MASK:     readdata = 32'(mask_q);
      ADDR_EDGE_CAPTURE: readdata = 32'(cap_q);
      ADDR_EDGE_SEL:     readdata = 32'(sel_q);
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_pcihellocore_key_in.sv
// Directed and randomized bench for pcihellocore_key_in against a sample-window reference model.
module tb_pcihellocore_key_in;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DC    = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  pcihellocore_key_in #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (16),
    .INIT_LEVEL      (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: synchroniser as a 2-deep delay, debounce as "last DC samples all disagree".
  logic [3:0] m_s1, m_s2, m_data, m_mask, m_cap, m_sel;
  logic       m_irq;
  logic [3:0] m_hist[$];

  logic [31:0] rd [4];
  logic        rd_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_data);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_cap);
      default: return 32'(m_sel);
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_data = 4'hF;
    m_mask = '0; m_cap = '0; m_sel = '0; m_irq = 1'b0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    logic [3:0] upd, nd, setv, clr;
    logic       all_diff;
    if (reset) begin
      model_reset();
      return;
    end
    m_hist.push_back(m_s2);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    upd = '0;
    if (m_hist.size() == DC) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][b] == m_data[b]) all_diff = 1'b0;
        upd[b] = all_diff;
      end
    end
    nd   = m_data ^ upd;
    setv = upd & ~(nd ^ m_sel);
    clr  = '0;
    if (chipselect && !write_n) begin
      case (address)
        2'd1:    m_mask = writedata[3:0];
        2'd2:    clr    = writedata[3:0];
        2'd3:    m_sel  = writedata[3:0];
        default: ;
      endcase
    end
    m_cap  = (m_cap & ~clr) | setv;
    m_data = nd;
    m_irq  = |(m_cap & m_mask);
    m_s2   = m_s1;
    m_s1   = in_port;
  endtask

  // One clock: advance model, then read back every register and irq against it.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      rd[a] = readdata;
      chk($sformatf("model reg%0d", a), readdata, model_reg(2'(a)));
    end
    rd_irq = irq;
    chk("model irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    reset = 1'b1; in_port = 4'hF; address = '0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    ticks(2);
    reset = 1'b0;
    tick();
    chk("reset data", rd[0], 32'h0000000F);
    chk("reset mask", rd[1], 32'h0);
    chk("reset cap",  rd[2], 32'h0);
    chk("reset sel",  rd[3], 32'h0);
    chk("reset irq",  32'(rd_irq), 32'h0);

    // Press bit0: DATA changes on edge 6 only.
    in_port = 4'hE;
    ticks(5);
    chk("press data edge5", rd[0], 32'hF);
    tick();
    chk("press data edge6", rd[0], 32'hE);
    chk("press cap edge6",  rd[2], 32'h1);
    chk("press irq masked", 32'(rd_irq), 32'h0);
    in_port = 4'hF;
    ticks(6);
    chk("release no capture", rd[2], 32'h1);
    bus_write(2'd2, 32'h1);
    chk("w1c cap", rd[2], 32'h0);

    // Unmasked press raises irq; clearing drops it.
    bus_write(2'd1, 32'h1);
    in_port = 4'hE;
    ticks(5);
    chk("irq before capture", 32'(rd_irq), 32'h0);
    tick();
    chk("irq on capture", 32'(rd_irq), 32'h1);
    bus_write(2'd2, 32'h1);
    chk("irq clear cap", rd[2], 32'h0);
    chk("irq cleared",   32'(rd_irq), 32'h0);
    in_port = 4'hF;
    ticks(6);

    // Glitch shorter than the debounce window is rejected; one exactly as long is accepted.
    in_port = 4'hD;
    ticks(3);
    in_port = 4'hF;
    ticks(8);
    chk("glitch3 data", rd[0], 32'hF);
    chk("glitch3 cap",  rd[2], 32'h0);
    in_port = 4'hD;
    ticks(4);
    in_port = 4'hF;
    ticks(8);
    chk("pulse4 cap",  rd[2], 32'h2);
    chk("pulse4 data", rd[0], 32'hF);
    chk("pulse4 irq",  32'(rd_irq), 32'h0);
    bus_write(2'd2, 32'hF);

    // Rising select on bit2; clear colliding with a new capture loses.
    bus_write(2'd3, 32'h4);
    in_port = 4'hB;
    ticks(8);
    chk("sel fall data", rd[0], 32'hB);
    chk("sel fall cap",  rd[2], 32'h0);
    in_port = 4'hF;
    ticks(5);
    bus_write(2'd2, 32'h4);
    chk("set beats clear", rd[2], 32'h4);
    chk("rise data",       rd[0], 32'hF);

    // Reset in the middle of activity.
    bus_write(2'd3, 32'h0);
    bus_write(2'd2, 32'hF);
    in_port = 4'hC;
    ticks(6);
    chk("pre-reset cap", rd[2], 32'h3);
    chk("pre-reset irq", 32'(rd_irq), 32'h1);
    in_port = 4'h0;
    reset = 1'b1;
    tick();
    chk("mid reset data", rd[0], 32'hF);
    chk("mid reset mask", rd[1], 32'h0);
    chk("mid reset cap",  rd[2], 32'h0);
    chk("mid reset irq",  32'(rd_irq), 32'h0);
    reset = 1'b0;
    ticks(5);
    chk("post reset edge5 cap", rd[2], 32'h0);
    tick();
    chk("post reset edge6 cap",  rd[2], 32'hF);
    chk("post reset edge6 data", rd[0], 32'h0);

    // Randomized traffic: held input levels of varied length interleaved with bus writes.
    for (int it = 0; it < 200; it++) begin
      int hold;
      in_port = 4'($urandom);
      hold = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 59) == 0) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus_write(2'($urandom), $urandom);
        end else begin
          tick();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
